fabric_port_tx: RTL and testbench

Synthesizable single-clock fabric-port transmit side. It takes a wide RTL word holding up to RATIO NoC flit slots and serializes the valid slots onto one NoC injection port, one flit per cycle. Flow control to the router is credit-based per VC. It generalizes the fixed 4-slot, unbounded simulation injector to any ratio, VC count and buffer depth, and adds protocol checking.

---
 rtl/fabric_port_pkg.sv | 31 +++
 rtl/fabric_credit_counter.sv | 42 ++++
 rtl/fabric_port_tx.sv | 197 +++++++++++++++++++
 tb/tb_fabric_port_tx.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_port_pkg.sv
// ----------------------------------------------------------------------------
// fabric_port_pkg
// Shared definitions for the fabric-port transmit block.
//   - Flit header field positions. They are offsets down from the flit MSB, so
//     one set of constants serves every flit width:
//     bit index = WIDTH_NOC-1-<FIELD>_POS.
//   - flit_hdr_t: decoded header (valid, head, tail, vc). The vc field is
//     sized for the widest supported VC address and zero-extended.
//   - credit_w(): width of a credit counter that has to hold 0..depth.
// No ports.
// ----------------------------------------------------------------------------
package fabric_port_pkg;

    localparam int VALID_POS  = 0;
    localparam int HEAD_POS   = 1;
    localparam int TAIL_POS   = 2;
    localparam int VC_POS     = 3;
    localparam int VC_FIELD_W = 8;

    typedef struct packed {
        logic                  valid;
        logic                  head;
        logic                  tail;
        logic [VC_FIELD_W-1:0] vc;
    } flit_hdr_t;

    function automatic int credit_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fabric_credit_counter.sv
// ----------------------------------------------------------------------------
// fabric_credit_counter
// One virtual channel's credit count toward the router input buffer. It
// resets to DEPTH, which is a full buffer's worth of credit.
//   clk      in   clock
//   rst      in   asynchronous reset, active-low
//   ret      in   one credit returned by the router this cycle
//   dec      in   one flit issued on this VC this cycle (only issued when count>0)
//   count    out  current credit count
//   overflow out  return arrived while already full (the count saturates)
// ----------------------------------------------------------------------------
module fabric_credit_counter
    import fabric_port_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = credit_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ret,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          overflow
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    assign overflow = ret && (count == FULL);

    // A return and an issue in the same cycle cancel out. A lone return at
    // FULL is held at FULL.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= FULL;
        end else if (ret && !dec && (count != FULL)) begin
            count <= count + 1'b1;
        end else if (dec && !ret) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/fabric_port_tx.sv
// ----------------------------------------------------------------------------
// fabric_port_tx
// Serializes the valid flit slots of a wide RTL word onto one NoC injection
// port, one flit per cycle, with credit-based flow control for each VC and a
// sticky protocol checker. Slot 0 sits in the MSBs of i_data.
//   clk           in   clock
//   rst           in   asynchronous reset, active-low
//   i_data        in   RTL word of RATIO flit slots
//   i_valid       in   i_data valid
//   o_ready       out  word accepted when i_valid & o_ready
//   noc_flit_out  out  registered flit to router
//   noc_valid_out out  registered flit valid
//   noc_credit_in in   per-VC credit return
//   o_vc_credits  out  per-VC credit counts, VC0 in the LSBs
//   o_proto_err   out  sticky protocol/credit error
// Optional build macro FABRIC_PORT_TX_STATS_EN adds three 32-bit counters:
//   o_stat_flits (flits issued), o_stat_pkts (tails issued) and
//   o_stat_stall (SEND cycles with no issue).
// ----------------------------------------------------------------------------
module fabric_port_tx
    import fabric_port_pkg::*;
#(
    parameter int WIDTH_NOC        = 128,
    parameter int RATIO            = 4,
    parameter int WIDTH_RTL        = WIDTH_NOC * RATIO,
    parameter int NUM_VC           = 2,
    parameter int DEPTH_PER_VC     = 8,
    parameter int VC_ADDRESS_WIDTH = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [WIDTH_RTL-1:0]                   i_data,
    input  logic                                   i_valid,
    output logic                                   o_ready,
    output logic [WIDTH_NOC-1:0]                   noc_flit_out,
    output logic                                   noc_valid_out,
    input  logic [NUM_VC-1:0]                      noc_credit_in,
    output logic [NUM_VC*credit_w(DEPTH_PER_VC)-1:0] o_vc_credits,
    output logic                                   o_proto_err
`ifdef FABRIC_PORT_TX_STATS_EN
    ,
    output logic [31:0]                            o_stat_flits,
    output logic [31:0]                            o_stat_pkts,
    output logic [31:0]                            o_stat_stall
`endif
);

    localparam int CW     = credit_w(DEPTH_PER_VC);
    localparam int SLOT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]           state;
    logic [WIDTH_RTL-1:0] hold_data;
    logic [WIDTH_NOC-1:0] hold_slot [RATIO];
    logic [RATIO-1:0]     pending;
    logic [RATIO-1:0]     in_mask;
    logic [RATIO-1:0]     slot_bit;
    logic [SLOT_W-1:0]    cur_slot;
    logic [WIDTH_NOC-1:0] cur_flit;
    flit_hdr_t            cur_hdr;
    logic                 vc_ok;
    logic                 has_credit;
    logic                 cur_open;
    logic                 issue;
    logic                 last_slot;
    logic                 accept;
    logic                 proto_hit;
    logic [NUM_VC-1:0]    dec_vec;
    logic [NUM_VC-1:0]    ovf_vec;
    logic [NUM_VC-1:0]    vc_open;
    logic [CW-1:0]        credit [NUM_VC];

    always_comb begin
        for (int j = 0; j < RATIO; j++) begin
            in_mask[j]   = i_data[WIDTH_RTL-1-WIDTH_NOC*j];
            hold_slot[j] = hold_data[WIDTH_RTL-1-WIDTH_NOC*j -: WIDTH_NOC];
        end
    end

    // Priority encoder. The loop runs downward so the lowest pending slot is
    // the last one written and wins. Invalid slots are never pending, so they
    // are skipped without costing a cycle.
    always_comb begin
        cur_slot = '0;
        for (int j = RATIO - 1; j >= 0; j--) begin
            if (pending[j]) cur_slot = SLOT_W'(j);
        end
    end

    assign cur_flit = hold_slot[cur_slot];
    assign slot_bit = RATIO'(1) << cur_slot;

    always_comb begin
        cur_hdr       = '0;
        cur_hdr.valid = cur_flit[WIDTH_NOC-1-VALID_POS];
        cur_hdr.head  = cur_flit[WIDTH_NOC-1-HEAD_POS];
        cur_hdr.tail  = cur_flit[WIDTH_NOC-1-TAIL_POS];
        cur_hdr.vc    = VC_FIELD_W'(cur_flit[WIDTH_NOC-1-VC_POS -: VC_ADDRESS_WIDTH]);
    end

    // A VC number beyond NUM_VC has no credit pool. The flit is sent anyway
    // so the port cannot deadlock, and it is flagged as a protocol error.
    always_comb begin
        vc_ok      = (int'(cur_hdr.vc) < NUM_VC);
        has_credit = !vc_ok;
        cur_open   = 1'b0;
        dec_vec    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (int'(cur_hdr.vc) == v) begin
                has_credit = (credit[v] != '0);
                cur_open   = vc_open[v];
                dec_vec[v] = issue;
            end
        end
    end

    assign issue     = (state == SEND) && has_credit;
    assign last_slot = ((pending & ~slot_bit) == '0);
    assign o_ready   = (state == IDLE) || (issue && last_slot);
    assign accept    = i_valid && o_ready;

    assign proto_hit = issue && (!vc_ok || !cur_hdr.valid ||
                                 (cur_hdr.head && cur_open) ||
                                 (!cur_hdr.head && !cur_open));

    always_ff @(posedge clk) begin
        if (accept) hold_data <= i_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pending <= '0;
        end else if (accept) begin
            pending <= in_mask;
            state   <= (|in_mask) ? SEND : IDLE;
        end else if (issue) begin
            pending <= pending & ~slot_bit;
            if (last_slot) state <= IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            noc_valid_out <= 1'b0;
            noc_flit_out  <= '0;
        end else begin
            noc_valid_out <= issue;
            if (issue) noc_flit_out <= cur_flit;
        end
    end

    // Open-packet tracking. A tail closes the VC, including a head+tail flit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vc_open     <= '0;
            o_proto_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (dec_vec[v]) vc_open[v] <= cur_hdr.tail ? 1'b0 : (cur_hdr.head | vc_open[v]);
            end
            o_proto_err <= o_proto_err | proto_hit | (|ovf_vec);
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_credit
        fabric_credit_counter #(
            .DEPTH (DEPTH_PER_VC),
            .CW    (CW)
        ) u_credit (
            .clk      (clk),
            .rst      (rst),
            .ret      (noc_credit_in[v]),
            .dec      (dec_vec[v]),
            .count    (credit[v]),
            .overflow (ovf_vec[v])
        );
        assign o_vc_credits[v*CW +: CW] = credit[v];
    end

`ifdef FABRIC_PORT_TX_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_stat_flits <= '0;
            o_stat_pkts  <= '0;
            o_stat_stall <= '0;
        end else begin
            if (issue) o_stat_flits <= o_stat_flits + 32'd1;
            if (issue && cur_hdr.tail) o_stat_pkts <= o_stat_pkts + 32'd1;
            if ((state == SEND) && !issue) o_stat_stall <= o_stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fabric_port_tx.sv
module tb_fabric_port_tx;

    localparam int WN = 128;
    localparam int R  = 4;
    localparam int WR = WN * R;
    localparam int NV = 2;
    localparam int D  = 8;
    localparam int CW = $clog2(D) + 1;

    logic          clk;
    logic          rst;
    logic [WR-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic [WN-1:0] noc_flit_out;
    logic          noc_valid_out;
    logic [NV-1:0] noc_credit_in;
    logic [NV*CW-1:0] o_vc_credits;
    logic          o_proto_err;
`ifdef FABRIC_PORT_TX_STATS_EN
    logic [31:0]   o_stat_flits;
    logic [31:0]   o_stat_pkts;
    logic [31:0]   o_stat_stall;
`endif

    fabric_port_tx #(
        .WIDTH_NOC    (WN),
        .RATIO        (R),
        .NUM_VC       (NV),
        .DEPTH_PER_VC (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .noc_flit_out  (noc_flit_out),
        .noc_valid_out (noc_valid_out),
        .noc_credit_in (noc_credit_in),
        .o_vc_credits  (o_vc_credits),
        .o_proto_err   (o_proto_err)
`ifdef FABRIC_PORT_TX_STATS_EN
        ,
        .o_stat_flits  (o_stat_flits),
        .o_stat_pkts   (o_stat_pkts),
        .o_stat_stall  (o_stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert;
    int n_fail;

    // Reference model: queue of flits still to send from the held word, a
    // credit pool per VC, open-packet flags and the sticky error.
    logic [WN-1:0] mq [$];
    int            cred [NV];
    bit            open_m [NV];
    bit            err_m;
    int            st_flits;
    int            st_pkts;
    int            st_stall;
    bit            exp_valid;
    logic [WN-1:0] exp_flit;

    task automatic chk(input string tag, input logic [WN-1:0] obs, input logic [WN-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WN-1:0] mk(input bit v, input bit h, input bit t, input int vc);
        logic [WN-1:0] f;
        f = {$urandom, $urandom, $urandom, $urandom};
        f[WN-1] = v;
        f[WN-2] = h;
        f[WN-3] = t;
        f[WN-4] = vc[0];
        return f;
    endfunction

    function automatic int crd(input int v);
        return int'(o_vc_credits[v*CW +: CW]);
    endfunction

    task automatic m_reset();
        mq.delete();
        for (int k = 0; k < NV; k++) begin
            cred[k]   = D;
            open_m[k] = 1'b0;
        end
        err_m    = 1'b0;
        st_flits = 0;
        st_pkts  = 0;
        st_stall = 0;
    endtask

    // One clock cycle: check o_ready before the edge, advance the model at
    // the edge, then check the registered outputs just after it.
    task automatic cyc();
        bit            iss;
        bit            rdy;
        int            v;
        logic [WN-1:0] f;
        logic [WN-1:0] s;
        int            pre [NV];
        #1;
        iss = 1'b0;
        if (mq.size() > 0) iss = (cred[int'(mq[0][WN-4])] > 0);
        rdy = (mq.size() == 0) || (iss && mq.size() == 1);
        chk("o_ready", o_ready, rdy);
        @(posedge clk);
        if (mq.size() > 0 && !iss) st_stall++;
        for (int k = 0; k < NV; k++) pre[k] = cred[k];
        exp_valid = iss;
        if (iss) begin
            f = mq.pop_front();
            v = int'(f[WN-4]);
            exp_flit = f;
            cred[v]--;
            if (f[WN-2] && open_m[v]) err_m = 1'b1;
            if (!f[WN-2] && !open_m[v]) err_m = 1'b1;
            if (f[WN-3]) open_m[v] = 1'b0;
            else if (f[WN-2]) open_m[v] = 1'b1;
            st_flits++;
            if (f[WN-3]) st_pkts++;
        end
        for (int k = 0; k < NV; k++) begin
            if (noc_credit_in[k]) begin
                if (pre[k] == D) err_m = 1'b1;
                if (cred[k] < D) cred[k]++;
            end
        end
        if (rdy && i_valid) begin
            for (int j = 0; j < R; j++) begin
                s = i_data[WR-1-WN*j -: WN];
                if (s[WN-1]) mq.push_back(s);
            end
        end
        #1;
        chk("noc_valid_out", noc_valid_out, exp_valid);
        if (exp_valid) chk("noc_flit_out", noc_flit_out, exp_flit);
        for (int k = 0; k < NV; k++) chk($sformatf("credit_vc%0d", k), crd(k), cred[k]);
        chk("o_proto_err", o_proto_err, err_m);
`ifdef FABRIC_PORT_TX_STATS_EN
        chk("stat_flits", o_stat_flits, st_flits);
        chk("stat_pkts", o_stat_pkts, st_pkts);
        chk("stat_stall", o_stat_stall, st_stall);
`endif
    endtask

    // Return every outstanding credit, one per VC per cycle, and drain the word.
    task automatic restore();
        int guard;
        guard = 0;
        while ((mq.size() > 0 || cred[0] < D || cred[1] < D) && guard < 64) begin
            for (int k = 0; k < NV; k++) noc_credit_in[k] = (cred[k] < D);
            cyc();
            guard++;
        end
        noc_credit_in = '0;
        chk("restore_bounded", guard < 64, 1);
    endtask

    logic [WN-1:0] f0, f1, f2, f3, g1, g3, h2;

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b0;
        i_valid       = 1'b0;
        i_data        = '0;
        noc_credit_in = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", noc_valid_out, 0);
        chk("rst_flit", noc_flit_out, 0);
        chk("rst_ready", o_ready, 1);
        chk("rst_err", o_proto_err, 0);
        for (int k = 0; k < NV; k++) chk("rst_credit", crd(k), D);
        @(negedge clk);
        rst = 1'b1;

        // Full word, one packet on VC0.
        f0 = mk(1, 1, 0, 0); f1 = mk(1, 0, 0, 0); f2 = mk(1, 0, 0, 0); f3 = mk(1, 0, 1, 0);
        i_data = {f0, f1, f2, f3}; i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        chk("t1_no_flit_at_accept", noc_valid_out, 0);
        chk("t1_ready_low", o_ready, 0);
        cyc();
        chk("t1_first_flit", noc_flit_out, f0);
        cyc(); cyc(); cyc();
        chk("t1_last_flit", noc_flit_out, f3);
        chk("t1_credit0", crd(0), 4);
        cyc();
        chk("t1_idle", noc_valid_out, 0);

        // Sparse word: slots 1 and 3 only, single-flit packets on VC1.
        g1 = mk(1, 1, 1, 1); g3 = mk(1, 1, 1, 1);
        i_data = {mk(0, 0, 0, 0), g1, mk(0, 1, 1, 0), g3}; i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        cyc();
        chk("t2_slot1", noc_flit_out, g1);
        cyc();
        chk("t2_slot3_no_gap", noc_valid_out, 1);
        chk("t2_slot3", noc_flit_out, g3);
        cyc();
        chk("t2_done", noc_valid_out, 0);
        i_data = {mk(0, 1, 0, 0), mk(0, 0, 0, 1), mk(0, 0, 1, 0), mk(0, 1, 1, 1)}; i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        chk("t2_empty_ready", o_ready, 1);
        cyc();
        chk("t2_empty_noflit", noc_valid_out, 0);

        // Credit exhaustion on VC1 (6 credits left).
        i_data = {mk(1, 1, 0, 1), mk(1, 0, 0, 1), mk(1, 0, 0, 1), mk(1, 0, 1, 1)}; i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        repeat (4) cyc();
        chk("t3_credit1_two", crd(1), 2);
        h2 = mk(1, 0, 0, 1);
        i_data = {mk(1, 1, 0, 1), mk(1, 0, 0, 1), h2, mk(1, 0, 1, 1)}; i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        cyc(); cyc();
        chk("t3_credit1_empty", crd(1), 0);
        repeat (4) cyc();
        chk("t3_stalled", noc_valid_out, 0);
`ifdef FABRIC_PORT_TX_STATS_EN
        chk("t3_stall_count", o_stat_stall, 4);
`endif
        noc_credit_in = 2'b10;
        cyc();
        noc_credit_in = '0;
        chk("t3_resume_wait", noc_valid_out, 0);
        cyc();
        chk("t3_resume_valid", noc_valid_out, 1);
        chk("t3_resume_flit", noc_flit_out, h2);
        cyc();
        chk("t3_stall_again", noc_valid_out, 0);
`ifdef FABRIC_PORT_TX_STATS_EN
        chk("t3_stall_count2", o_stat_stall, 6);
`endif
        restore();

        // Same-cycle return and issue on VC0.
        i_data = {mk(1, 1, 0, 0), mk(1, 0, 0, 0), mk(1, 0, 0, 0), mk(1, 0, 1, 0)}; i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        cyc();
        chk("t4_after_one", crd(0), 7);
        noc_credit_in = 2'b01;
        cyc();
        noc_credit_in = '0;
        chk("t4_same_cycle", crd(0), 7);
        cyc(); cyc();
        chk("t4_after_four", crd(0), 5);
        restore();

        // Second head on an open VC0.
        f0 = mk(1, 1, 0, 0); f1 = mk(1, 1, 0, 0);
        i_data = {f0, f1, mk(0, 0, 0, 0), mk(0, 1, 1, 1)}; i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        cyc();
        chk("t5_first_head_ok", o_proto_err, 0);
        cyc();
        chk("t5_second_head_err", o_proto_err, 1);
        chk("t5_forwarded_valid", noc_valid_out, 1);
        chk("t5_forwarded_flit", noc_flit_out, f1);
        restore();

        // Reset with two flits still pending.
        i_data = {mk(1, 1, 0, 1), mk(1, 0, 0, 1), mk(1, 0, 0, 1), mk(1, 0, 1, 1)}; i_valid = 1'b1;
        cyc();
        i_valid = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        chk("t6_valid_zero", noc_valid_out, 0);
        chk("t6_flit_zero", noc_flit_out, 0);
        chk("t6_err_cleared", o_proto_err, 0);
        chk("t6_ready", o_ready, 1);
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) cyc();
        chk("t6_credit0", crd(0), D);
        chk("t6_credit1", crd(1), D);

        // Credit return while full.
        noc_credit_in = 2'b01;
        cyc();
        noc_credit_in = '0;
        chk("t4_sat_err", o_proto_err, 1);
        chk("t4_sat_credit", crd(0), D);

        // Randomized traffic against the model.
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_reset();
        for (int i = 0; i < 500; i++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < R; j++) begin
                i_data[WR-1-WN*j -: WN] = mk($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                                             $urandom_range(0, 1) == 1, int'($urandom_range(0, NV - 1)));
            end
            for (int k = 0; k < NV; k++) noc_credit_in[k] = (cred[k] < D) && ($urandom_range(0, 2) == 0);
            cyc();
        end
        i_valid = 1'b0;
        noc_credit_in = '0;
        restore();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
